// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU issue sequencer: instruction classes, ALU selects,
// FSM states and instruction field positions.
package alu_sequencer_pkg;

  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_BEQ = 2'b01;
  localparam logic [1:0] CLS_LI  = 2'b10;
  localparam logic [1:0] CLS_RSV = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  localparam int CLS_LSB  = 14;
  localparam int FUNC_LSB = 12;
  localparam int RD_LSB   = 9;
  localparam int RS_LSB   = 6;
  localparam int RT_LSB   = 3;
  localparam int IMM_W    = 9;

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file with two operand read ports, a debug read port and one write port.
// r0 always reads zero and ignores writes; reads return the pre-write value.
module regfile_8x32 #(
  parameter int NREGS = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  output logic [DW-1:0]            ra_data,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [DW-1:0]            rb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [DW-1:0]            wd
);

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem_q[wa] <= wd;
    end
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : mem_q[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : mem_q[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state issue controller: accepts one instruction, presents operands to the
// external ALU, captures its result and retires with writeback or a branch decision.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_instr,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [1:0]               alu_sel,
  input  logic [DW-1:0]            alu_out,
  input  logic                     alu_zero,
  output logic                     done,
  output logic [DW-1:0]            result,
  output logic                     branch_taken,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t        state_q, state_d;
  logic [1:0]    cls_q, cls_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [1:0]    alu_sel_q, alu_sel_d;
  logic [DW-1:0] result_q, result_d;
  logic          zero_q, zero_d;

  logic [1:0]    in_cls;
  logic [AW-1:0] rs_addr, rt_addr;
  logic [DW-1:0] rs_data, rt_data;
  logic          wb_en;

  assign in_cls  = in_instr[CLS_LSB +: 2];
  assign rs_addr = in_instr[RS_LSB +: AW];
  assign rt_addr = in_instr[RT_LSB +: AW];

  regfile_8x32 #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (rs_addr),
    .ra_data  (rs_data),
    .rb_addr  (rt_addr),
    .rb_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_en),
    .wa       (rd_q),
    .wd       (result_q)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    rd_d      = rd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cls_d   = in_cls;
          rd_d    = in_instr[RD_LSB +: AW];
          state_d = EXEC;
          case (in_cls)
            CLS_LI: begin
              alu_a_d   = {{(DW-IMM_W){1'b0}}, in_instr[IMM_W-1:0]};
              alu_b_d   = '0;
              alu_sel_d = ALU_ADD;
            end
            CLS_BEQ: begin
              alu_a_d   = rs_data;
              alu_b_d   = rt_data;
              alu_sel_d = ALU_SUB;
            end
            default: begin
              alu_a_d   = rs_data;
              alu_b_d   = rt_data;
              alu_sel_d = in_instr[FUNC_LSB +: 2];
            end
          endcase
        end
      end
      EXEC: begin
        result_d = alu_out;
        zero_d   = alu_zero;
        state_d  = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cls_q     <= CLS_R;
      rd_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= ALU_ADD;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      rd_q      <= rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  // Retire indications are decoded from the WB state so a reset drops them at once.
  assign in_ready     = (state_q == IDLE);
  assign done         = (state_q == WB);
  assign branch_taken = done && (cls_q == CLS_BEQ) && zero_q;
  assign illegal      = done && (cls_q == CLS_RSV);
  assign wb_en        = done && ((cls_q == CLS_R) || (cls_q == CLS_LI));

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign result  = result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised self-checking bench for alu_sequencer against a register-array model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic        alu_zero;
  logic        done, branch_taken, illegal;
  logic [31:0] result;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] model [8];
  logic [15:0] instr_q [$];

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(8), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .done         (done),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // The ALU the sequencer drives
  always_comb begin
    case (alu_sel)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] c, input logic [1:0] f,
                                     input logic [2:0] rd, input logic [2:0] rs,
                                     input logic [2:0] rt);
    return {c, f, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] mk_li(input logic [2:0] rd, input logic [8:0] imm);
    return {2'b10, 2'b00, rd, imm};
  endfunction

  function automatic logic [31:0] apply_op(input logic [1:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    case (f)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic reg_check(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Drives n_instr instructions (from instr_q or random) and checks every cycle.
  task automatic run_stream(input int n_instr, input int valid_pct, input bit from_q);
    int issued = 0;
    int budget = 0;
    bit pending = 0;
    int acc_cyc = -10;
    int last_acc = -10;
    logic [15:0] ins;
    logic [1:0]  cls, fn, e_sel;
    logic [2:0]  e_rd;
    logic [31:0] e_a, e_b, e_res;
    bit e_br, e_ill, e_we, e_rsv, exp_done, exp_ready;
    e_sel = 0; e_rd = 0; e_a = 0; e_b = 0; e_res = 0;
    e_br = 0; e_ill = 0; e_we = 0; e_rsv = 0;
    while ((issued < n_instr || pending) && budget < 20 * n_instr + 20) begin
      @(negedge clk);
      cyc++;
      budget++;
      check("dbg_data", dbg_data, model[dbg_addr]);
      exp_ready = !pending;
      exp_done  = pending && (cyc - acc_cyc == 2);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("done", 32'(done), 32'(exp_done));
      check("branch_taken", 32'(branch_taken), 32'(exp_done && e_br));
      check("illegal", 32'(illegal), 32'(exp_done && e_ill));
      if (pending && (cyc - acc_cyc == 1) && !e_rsv) begin
        check("alu_sel", 32'(alu_sel), 32'(e_sel));
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
      end
      if (exp_done) begin
        if (!e_rsv) check("result", result, e_res);
        if (e_we && e_rd != 3'd0) model[e_rd] = e_res;
        pending = 0;
      end
      dbg_addr = 3'($urandom_range(0, 7));
      if (exp_ready && issued < n_instr && $urandom_range(0, 99) < valid_pct) begin
        ins = from_q ? instr_q.pop_front() : 16'($urandom);
        in_valid = 1'b1;
        in_instr = ins;
        cls  = ins[15:14];
        fn   = ins[13:12];
        e_rd = ins[11:9];
        e_a  = model[ins[8:6]];
        e_b  = model[ins[5:3]];
        e_br = 0; e_ill = 0; e_we = 0; e_rsv = 0;
        case (cls)
          2'b00: begin e_sel = fn; e_we = 1; end
          2'b01: begin e_sel = 2'b01; e_br = (e_a == e_b); end
          2'b10: begin e_a = {23'd0, ins[8:0]}; e_b = 0; e_sel = 2'b00; e_we = 1; end
          default: begin e_ill = 1; e_rsv = 1; end
        endcase
        e_res = apply_op(e_sel, e_a, e_b);
        if (valid_pct == 100 && last_acc >= 0) check("accept_gap", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
        acc_cyc  = cyc;
        pending  = 1;
        issued++;
      end else begin
        in_valid = exp_ready ? 1'b0 : 1'($urandom_range(0, 1));
        in_instr = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    if (issued < n_instr || pending) check("stream_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'd0;
    dbg_addr = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) reg_check(3'(i), 32'd0, "rst_reg");

    // Directed sequence: loads, wrapping subtract, branches, reserved, write to r0
    instr_q.push_back(mk_li(3'd1, 9'd5));
    instr_q.push_back(mk_li(3'd2, 9'd3));
    instr_q.push_back(mk(2'b00, 2'b01, 3'd3, 3'd1, 3'd2));
    instr_q.push_back(mk(2'b00, 2'b01, 3'd4, 3'd2, 3'd1));
    instr_q.push_back(mk(2'b01, 2'b10, 3'd6, 3'd1, 3'd1));
    instr_q.push_back(mk(2'b01, 2'b00, 3'd6, 3'd1, 3'd2));
    instr_q.push_back(mk(2'b11, 2'b00, 3'd7, 3'd1, 3'd2));
    instr_q.push_back(mk(2'b00, 2'b00, 3'd0, 3'd1, 3'd2));
    run_stream(8, 100, 1'b1);
    reg_check(3'd1, 32'd5, "dir_r1");
    reg_check(3'd2, 32'd3, "dir_r2");
    reg_check(3'd3, 32'd2, "dir_r3");
    reg_check(3'd4, 32'hFFFF_FFFE, "dir_r4");
    reg_check(3'd6, 32'd0, "dir_r6");
    reg_check(3'd7, 32'd0, "dir_r7");
    reg_check(3'd0, 32'd0, "dir_r0");

    run_stream(40, 100, 1'b0);
    run_stream(300, 50, 1'b0);

    // Reset during EXEC of LI r5,#7 aborts the instruction
    @(negedge clk);
    cyc++;
    in_valid = 1'b1;
    in_instr = mk_li(3'd5, 9'd7);
    @(negedge clk);
    cyc++;
    in_valid = 1'b0;
    check("abort_exec_a", alu_a, 32'd7);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cyc++;
      check("abort_no_done", 32'(done), 32'd0);
    end
    reg_check(3'd5, 32'd0, "abort_r5");
    reg_check(3'd1, 32'd0, "abort_r1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle issue controller that drives the 32-bit ALU, acting as the initiator side of the ALU operand/select/result interface. It accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from an internal 8x32 register file. It presents A/B/sel to the ALU, then captures the ALU result and zero flag. It writes the result back to the register file or reports a branch decision. It sits between the instruction source and the ALU in the RISC datapath.

Parameters:
NREGS, 8, number of architectural registers (r0 hardwired to zero); register index width is clog2(NREGS)=3
DW, 32, datapath width; must match the ALU width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  instruction valid
in_ready  out  1  sequencer can accept an instruction
in_instr  in  16  instruction word
alu_a  out  DW  ALU operand A (registered)
alu_b  out  DW  ALU operand B (registered)
alu_sel  out  2  ALU op select: 00 add, 01 sub, 10 and, 11 or
alu_out  in  DW  ALU result (combinational from alu_a/alu_b/alu_sel)
alu_zero  in  1  ALU zero flag (1 when alu_out==0)
done  out  1  one-cycle pulse: instruction retired
result  out  DW  captured alu_out, valid while done=1, held afterwards
branch_taken  out  1  one-cycle pulse with done for a BEQ whose operands are equal
illegal  out  1  one-cycle pulse with done for a reserved class
dbg_addr  in  3  debug register read index
dbg_data  out  DW  combinational register file read (r0 always reads 0)

Behaviour:
- Instruction format: [15:14] class, [13:12] func, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] ignored.
- Class 00 = R-type: rd = rs func rt.
- Class 01 = BEQ: sel forced to 01 (sub), no writeback, branch_taken = alu_zero.
- Class 10 = LI: alu_a = zero-extended in_instr[8:0], alu_b = 0, sel = 00, rd = result.
- Class 11 = reserved: no writeback, illegal pulses.
- FSM states: IDLE, EXEC, WB.
  - IDLE: in_ready=1. On in_valid&&in_ready (cycle T), latch class/rd. Load alu_a/alu_b from the register file (async read of rs/rt, or the LI immediate) and load alu_sel. Go to EXEC.
  - EXEC (T+1): alu_a/alu_b/alu_sel are stable. At the clock edge, capture alu_out into result and alu_zero into an internal flag. Go to WB.
  - WB (T+2): done=1. branch_taken/illegal are asserted per class. For classes 00 and 10 with rd!=0, the register file writes result at the end of this cycle. Go to IDLE.
  - Next accept is possible at T+3. Retire latency is 2 cycles; throughput is one instruction per 3 cycles.
- in_ready=0 in EXEC and WB. in_valid is ignored while in_ready=0. in_instr is sampled only on the accept cycle.
- Writes to r0 are discarded; r0 and dbg_data at index 0 always read 0.
- Read-during-write: dbg_data (or an operand read) of the register being written in WB returns the old value; the new value is visible from T+3.
- Reset values: state=IDLE, all registers=0, alu_a=alu_b=0, alu_sel=00, result=0, done=branch_taken=illegal=0. in_ready=1 after reset is released.
- Reset asserted mid-instruction aborts it: no writeback, no done.
- Arithmetic wraps modulo 2^DW; no overflow/carry detection.
- alu_a/alu_b/alu_sel hold their values outside EXEC.

Decomposition:
- Shared package holds:
  - class encodings: CLS_R=2'b00, CLS_BEQ=2'b01, CLS_LI=2'b10, CLS_RSV=2'b11
  - ALU select constants: ALU_ADD/SUB/AND/OR
  - FSM state typedef
  - instruction field bit positions
- One natural sub-module: regfile_8x32, with 2 async read ports, 1 debug read port, 1 sync write port, r0 hardwired to zero, and async reset.

Test Plan:
- Reset then LI r1,#5; LI r2,#3: done at T+2 each, result=5 then 3; dbg r1=5, r2=3.
- R-type sub r3=r1-r2 -> alu_sel=01 in EXEC, result=2, r3=2. Then sub r4=r2-r1 -> result=0xFFFFFFFE (wrap).
- BEQ r1,r1 -> branch_taken=1 with done, no register changes. BEQ r1,r2 -> done=1, branch_taken=0.
- Class 11 instruction and an R-type add with rd=0 -> illegal=1 / done=1, and dbg r0 stays 0.
- in_valid held high continuously: in_ready low in EXEC/WB, exactly one accept per 3 cycles, no instruction dropped or duplicated.
- Assert rst during EXEC of LI r5,#7 -> outputs return to reset values immediately, r5=0, no done pulse.
